// File: rtl/s2neuron_pkg.sv
// Shared definitions for the s2neuron sequencer: FSM state codes, counter widths
// and per-lane helpers on the packed N*DW result vector.
package s2neuron_pkg;
   localparam int DW          = 32;
   localparam int N_DEF       = 8;
   localparam int S_DEF       = 8;
   localparam int MAC_LAT_DEF = 1;

   // Counters are at least one bit wide so S=1 / MAC_LAT=1 builds stay legal.
   function automatic int cnt_w(input int range);
      return (range > 1) ? $clog2(range) : 1;
   endfunction

   localparam int STEP_W = cnt_w(S_DEF);
   localparam int LAT_W  = cnt_w(MAC_LAT_DEF + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_ACCUM = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_OUT   = 3'd4;

   function automatic int lane_lo(input int lane);
      return lane * DW;
   endfunction

   function automatic logic [DW-1:0] relu_word(input logic [DW-1:0] w);
      return w[DW-1] ? '0 : w;
   endfunction
endpackage

// File: rtl/s2neuron_seq_if.sv
// Handshake and MAC-side bus between the s2neuron sequencer and its neighbours.
// slave = sequencer side, master = the upstream/MAC/downstream environment.
interface s2neuron_seq_if #(
   parameter int N = s2neuron_pkg::N_DEF,
   parameter int S = s2neuron_pkg::S_DEF
);
   import s2neuron_pkg::*;

   localparam int SW = cnt_w(S);

   logic [DW-1:0]   h_in;
   logic            h_valid;
   logic            h_ready;
   logic [DW-1:0]   mac_h;
   logic            mac_clr;
   logic [SW-1:0]   w_addr;
   logic [N*DW-1:0] y_in;
   logic [N*DW-1:0] y_out;
   logic            y_valid;
   logic            y_ready;
   logic            busy;

   modport slave (
      input  h_in, h_valid, y_in, y_ready,
      output h_ready, mac_h, mac_clr, w_addr, y_out, y_valid, busy
   );

   modport master (
      output h_in, h_valid, y_in, y_ready,
      input  h_ready, mac_h, mac_clr, w_addr, y_out, y_valid, busy
   );
endinterface

// File: rtl/s2neuron_relu.sv
// Per-lane ReLU on signed two's-complement words; purely combinational, no latency.
module s2neuron_relu
   import s2neuron_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic [N*DW-1:0] y_i,
   output logic [N*DW-1:0] y_o
);
   for (genvar g = 0; g < N; g++) begin : g_lane
      localparam int LO = lane_lo(g);
      assign y_o[LO +: DW] = relu_word(y_i[LO +: DW]);
   end
endmodule

// File: rtl/s2neuron_seq.sv
// s2neuron_seq: streams S activation beats onto the shared H bus, then captures the drained
// lane sums and offers them downstream. Define S2NEURON_SEQ_RELU_EN to apply ReLU at capture.
module s2neuron_seq
   import s2neuron_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int S       = S_DEF,
   parameter int MAC_LAT = MAC_LAT_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   s2neuron_seq_if.slave  sq
);
   localparam int STEP_BITS = cnt_w(S);
   localparam int LAT_BITS  = cnt_w(MAC_LAT + 1);
   localparam logic [STEP_BITS-1:0] STEP_LAST = STEP_BITS'(S - 1);
   localparam logic [LAT_BITS-1:0]  LAT_LAST  = LAT_BITS'(MAC_LAT - 1);

   logic [2:0]           state_q, state_d;
   logic [STEP_BITS-1:0] step_q, step_d;
   logic [STEP_BITS-1:0] waddr_q, waddr_d;
   logic [LAT_BITS-1:0]  lat_q, lat_d;
   logic [N*DW-1:0]      y_q, y_d;
   logic                 yv_q, yv_d;
   logic [N*DW-1:0]      cap_y;

`ifdef S2NEURON_SEQ_RELU_EN
   s2neuron_relu #(.N(N)) u_relu (
      .y_i (sq.y_in),
      .y_o (cap_y)
   );
`else
   assign cap_y = sq.y_in;
`endif

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      waddr_d    = waddr_q;
      lat_d      = lat_q;
      y_d        = y_q;
      yv_d       = yv_q;
      sq.h_ready = 1'b0;
      sq.mac_h   = '0;
      sq.mac_clr = 1'b0;
      sq.w_addr  = waddr_q;
      case (state_q)
         ST_IDLE: begin
            if (sq.h_valid) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            sq.mac_clr = 1'b1;
            step_d     = '0;
            state_d    = ST_ACCUM;
         end
         ST_ACCUM: begin
            sq.h_ready = 1'b1;
            // Bubbles drive zero on H, so every lane accumulates nothing that cycle.
            if (sq.h_valid) begin
               sq.mac_h  = sq.h_in;
               sq.w_addr = step_q;
               waddr_d   = step_q;
               if (step_q == STEP_LAST) begin
                  lat_d   = '0;
                  state_d = ST_DRAIN;
               end else begin
                  step_d = step_q + STEP_BITS'(1);
               end
            end
         end
         ST_DRAIN: begin
            lat_d = lat_q + LAT_BITS'(1);
            if (lat_q == LAT_LAST) begin
               y_d     = cap_y;
               yv_d    = 1'b1;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (sq.y_ready) begin
               yv_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         waddr_q <= '0;
         lat_q   <= '0;
         y_q     <= '0;
         yv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         waddr_q <= waddr_d;
         lat_q   <= lat_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
      end
   end

   assign sq.y_out   = y_q;
   assign sq.y_valid = yv_q;
   assign sq.busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_s2neuron_seq.sv
// Bench for s2neuron_seq with a behavioural rmac/W-bank model (N=2, S=4, MAC_LAT=1);
// expected vectors come from plain dot products of the beats against the weight table.
module tb_s2neuron_seq;
   import s2neuron_pkg::*;

   localparam int N       = 2;
   localparam int S       = 4;
   localparam int MAC_LAT = 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [DW-1:0]   h_in;
   logic            h_valid;
   logic            y_ready;
   logic [N*DW-1:0] y_in;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int clr_cnt = 0;
   logic [1:0]    wa_q [$];
   logic [DW-1:0] hv  [S];
   int            gap [S];
   logic [DW-1:0] wt  [N][S];
   logic [DW-1:0] acc [N];

   s2neuron_seq_if #(.N(N), .S(S)) bus ();

   assign bus.h_in    = h_in;
   assign bus.h_valid = h_valid;
   assign bus.y_ready = y_ready;
   assign bus.y_in    = y_in;

   s2neuron_seq #(.N(N), .S(S), .MAC_LAT(MAC_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sq    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // rmac lanes: clear, or add H times the addressed weight row; sum settles one cycle later.
   always @(posedge clk) begin
      for (int l = 0; l < N; l++) begin
         if (bus.mac_clr) acc[l] <= '0;
         else             acc[l] <= acc[l] + bus.mac_h * wt[l][bus.w_addr];
      end
   end

   always_comb begin
      y_in = '0;
      for (int l = 0; l < N; l++) y_in[l*DW +: DW] = acc[l];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (h_valid && bus.h_ready) begin
            wa_q.push_back(bus.w_addr);
            chk("mac_h_beat", 64'(bus.mac_h), 64'(h_in));
         end else begin
            chk("mac_h_zero", 64'(bus.mac_h), 64'd0);
         end
         if (bus.mac_clr) clr_cnt++;
      end
   end

   function automatic logic [N*DW-1:0] ref_y();
      logic [N*DW-1:0] r;
      logic [DW-1:0]   s;
      r = '0;
      for (int l = 0; l < N; l++) begin
         s = '0;
         for (int i = 0; i < S; i++) s = s + hv[i] * wt[l][i];
`ifdef S2NEURON_SEQ_RELU_EN
         if (s[DW-1]) s = '0;
`endif
         r[l*DW +: DW] = s;
      end
      return r;
   endfunction

   task automatic chk_reset(input string tg);
      chk({tg, " h_ready"}, 64'(bus.h_ready), 64'd0);
      chk({tg, " mac_clr"}, 64'(bus.mac_clr), 64'd0);
      chk({tg, " mac_h"},   64'(bus.mac_h),   64'd0);
      chk({tg, " w_addr"},  64'(bus.w_addr),  64'd0);
      chk({tg, " y_out"},   64'(bus.y_out),   64'd0);
      chk({tg, " y_valid"}, 64'(bus.y_valid), 64'd0);
      chk({tg, " busy"},    64'(bus.busy),    64'd0);
   endtask

   task automatic send_beats(input string tg, input int nb);
      bit ok;
      for (int i = 0; i < nb; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap[i]; g++) begin
               h_valid = 1'b0;
               h_in    = $urandom;
               @(posedge clk); #1;
            end
         end
         h_valid = 1'b1;
         h_in    = hv[i];
         if (i == 0) t0 = cyc;
         ok = 1'b0;
         for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = bus.h_ready;
            if (!ok) begin @(posedge clk); #1; end
         end
         chk({tg, " beat_hs"}, 64'(ok), 64'd1);
         @(posedge clk); #1;
      end
      h_valid = 1'b0;
      h_in    = $urandom;
   endtask

   task automatic run_vec(input string tg, input int rdy_dly, input bit early,
                          input bit tim, input bit pre_hv);
      logic [N*DW-1:0] ey;
      bit ok;
      int tv;
      ey      = ref_y();
      clr_cnt = 0;
      wa_q.delete();
      y_ready = early;
      send_beats(tg, S);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         ok = bus.y_valid;
      end
      chk({tg, " y_valid_rise"}, 64'(ok), 64'd1);
      tv = cyc;
      if (tim) chk({tg, " latency"}, 64'(tv - t0), 64'd7);
      chk({tg, " y_out"}, 64'(bus.y_out), 64'(ey));
      chk({tg, " clr_count"}, 64'(clr_cnt), 64'd1);
      chk({tg, " n_waddr"}, 64'(wa_q.size()), 64'(S));
      for (int i = 0; i < S; i++)
         if (i < wa_q.size()) chk({tg, " w_addr_seq"}, 64'(wa_q[i]), 64'(i));
      if (early) begin
         @(negedge clk);
         chk({tg, " busy_after"}, 64'(bus.busy), 64'd0);
         chk({tg, " y_valid_drop"}, 64'(bus.y_valid), 64'd0);
         @(posedge clk); #1;
         y_ready = 1'b0;
      end else begin
         for (int d = 0; d < rdy_dly; d++) begin
            @(posedge clk); #1;
            if (pre_hv) begin h_valid = 1'b1; h_in = $urandom; end
            @(negedge clk);
            chk({tg, " hold_valid"}, 64'(bus.y_valid), 64'd1);
            chk({tg, " hold_y"},     64'(bus.y_out),   64'(ey));
            chk({tg, " hold_hrdy"},  64'(bus.h_ready), 64'd0);
            chk({tg, " hold_busy"},  64'(bus.busy),    64'd1);
         end
         @(posedge clk); #1;
         y_ready = 1'b1;
         @(negedge clk);
         chk({tg, " valid_at_hs"}, 64'(bus.y_valid), 64'd1);
         @(posedge clk); #1;
         y_ready = 1'b0;
         @(negedge clk);
         chk({tg, " valid_after_hs"}, 64'(bus.y_valid), 64'd0);
      end
   endtask

   task automatic set_s1_weights();
      for (int i = 0; i < S; i++) begin
         wt[0][i] = DW'(i + 1);
         wt[1][i] = DW'(1);
         gap[i]   = 0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      h_in    = '0;
      h_valid = 1'b0;
      y_ready = 1'b0;
      set_s1_weights();
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back beats
      hv = '{32'd1, 32'd2, 32'd3, 32'd4};
      run_vec("t1", 2, 1'b0, 1'b1, 1'b0);

      // Two-cycle bubble between beats 2 and 3
      gap[2] = 2;
      run_vec("t2", 1, 1'b0, 1'b0, 1'b0);
      gap[2] = 0;

      // Downstream backpressure with a new vector waiting upstream
      run_vec("t3", 5, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < S; i++) hv[i] = $urandom;
      run_vec("t3b", 0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of accumulation
      for (int i = 0; i < S; i++) hv[i] = $urandom;
      send_beats("t4p", 2);
      #1 rst_n = 1'b0;
      #1 chk_reset("t4rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      hv = '{32'd1, 32'd1, 32'd1, 32'd1};
      run_vec("t4", 0, 1'b0, 1'b1, 1'b0);

      // Negative sum, ReLU-sensitive
      hv = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
      run_vec("t5", 1, 1'b0, 1'b0, 1'b0);

      // y_ready already high when y_valid rises
      hv = '{32'd4, 32'd3, 32'd2, 32'd1};
      run_vec("t6", 0, 1'b1, 1'b1, 1'b0);

      for (int r = 0; r < 8; r++) begin
         for (int l = 0; l < N; l++)
            for (int i = 0; i < S; i++) wt[l][i] = $urandom;
         for (int i = 0; i < S; i++) begin
            hv[i]  = $urandom;
            gap[i] = $urandom_range(0, 2);
         end
         run_vec("rnd", $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
